// File: rtl/tdc_therm_decoder_if.sv
// rtl/tdc_therm_decoder_if.sv - sample-in / code-out bundle of the TDC thermometer decoder
interface tdc_therm_decoder_if #(
    parameter int TAP_W = 90,
    parameter int OUT_W = $clog2(TAP_W + 1)
) ();
    logic             in_valid;
    logic [TAP_W-1:0] Q;
    logic             out_valid;
    logic [OUT_W-1:0] code;
    logic             bubble;
    logic             full;
    logic             empty;

    modport master (
        output in_valid, Q,
        input  out_valid, code, bubble, full, empty
    );

    modport slave (
        input  in_valid, Q,
        output out_valid, code, bubble, full, empty
    );
endinterface

// File: rtl/tdc_therm_decoder.sv
// rtl/tdc_therm_decoder.sv - pipelined thermometer-to-binary decoder for the TDC delay-line word
module tdc_therm_decoder #(
    parameter int TAP_W = 90,
    parameter int GROUP = 6,
    parameter int MODE  = 0,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_cnt,
    tdc_therm_decoder_if.slave bus
);
    localparam int NG    = (TAP_W + GROUP - 1) / GROUP;
    localparam int LV    = (NG > 1) ? $clog2(NG) : 0;
    localparam int OUT_W = $clog2(TAP_W + 1);
    localparam int LAT   = 2 + LV;
    // side word carried next to the tree: {edge index, bubble, full, empty}
    localparam int SW    = OUT_W + 3;

    // number of partial sums present at tree level l (level 0 = group counts)
    function automatic int nlev(input int l);
        int n;
        n = NG;
        for (int i = 0; i < l; i++) n = (n + 1) / 2;
        return n;
    endfunction

    // bit offset of tree level l inside the flat tree vector
    function automatic int offs(input int l);
        int o;
        o = 0;
        for (int i = 0; i < l; i++) o = o + nlev(i) * OUT_W;
        return o;
    endfunction

    localparam int TREE_W = offs(LV + 1);

    logic [TAP_W-1:0]    q_r;
    logic [LAT-1:0]      vld;
    logic [NG*GROUP-1:0] q_pad;
    logic [NG*OUT_W-1:0] grp_cnt;
    logic [OUT_W-1:0]    edge_idx;
    logic                bub_c;
    logic                full_c;
    logic                empty_c;
    logic [TREE_W-1:0]   tree;
    logic [SW-1:0]       side [LV+1];

    // stage 0: capture the tap word only when a sample is offered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= '0;
        end else if (bus.in_valid) begin
            q_r <= bus.Q;
        end
    end

    // valid shift register; reset discards every in-flight sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            vld <= {vld[LAT-2:0], bus.in_valid};
        end
    end

    // stage 1 logic: group popcounts, highest-one edge index, bubble and extreme-code terms
    always_comb begin
        q_pad            = '0;
        q_pad[TAP_W-1:0] = q_r;
        grp_cnt          = '0;
        for (int g = 0; g < NG; g++) begin
            for (int b = 0; b < GROUP; b++) begin
                grp_cnt[g*OUT_W +: OUT_W] = grp_cnt[g*OUT_W +: OUT_W] + OUT_W'(q_pad[g*GROUP+b]);
            end
        end
        edge_idx = '0;
        for (int i = 0; i < TAP_W; i++) begin
            if (q_r[i]) edge_idx = OUT_W'(i + 1);
        end
        // a 0 directly below a 1 anywhere in the chain, group boundaries included
        bub_c   = |(~q_r[TAP_W-2:0] & q_r[TAP_W-1:1]);
        full_c  = &q_r;
        empty_c = ~|q_r;
    end

    // stage 1 register: group counts form tree level 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tree[0 +: NG*OUT_W] <= '0;
        end else if (vld[0]) begin
            tree[0 +: NG*OUT_W] <= grp_cnt;
        end
    end

    // stages 2..LAT: one pairwise adder level per stage
    for (genvar l = 0; l < LV; l++) begin : g_lvl
        localparam int NI = nlev(l);
        localparam int NO = nlev(l + 1);
        localparam int OI = offs(l);
        localparam int OO = offs(l + 1);

        // pair neighbours; an odd leftover operand is passed through registered
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tree[OO +: NO*OUT_W] <= '0;
            end else if (vld[l+1]) begin
                for (int j = 0; j < NO; j++) begin
                    if (2*j + 1 < NI) begin
                        tree[OO + j*OUT_W +: OUT_W] <= tree[OI + 2*j*OUT_W +: OUT_W]
                                                     + tree[OI + (2*j+1)*OUT_W +: OUT_W];
                    end else begin
                        tree[OO + j*OUT_W +: OUT_W] <= tree[OI + 2*j*OUT_W +: OUT_W];
                    end
                end
            end
        end
    end

    // edge index and flags delayed stage by stage to stay aligned with the tree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l <= LV; l++) side[l] <= '0;
        end else begin
            if (vld[0]) side[0] <= {edge_idx, bub_c, full_c, empty_c};
            for (int l = 0; l < LV; l++) begin
                if (vld[l+1]) side[l+1] <= side[l];
            end
        end
    end

    // outputs come straight from the last stage, so they hold while out_valid is low
    assign bus.out_valid = vld[LAT-1];
    assign bus.code      = (MODE == 1) ? side[LV][SW-1:3] : tree[offs(LV) +: OUT_W];
    assign bus.bubble    = side[LV][2];
    assign bus.full      = side[LV][1];
    assign bus.empty     = side[LV][0];

    // saturating bubble counter; a clear still counts a coincident bubble output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= (bus.out_valid && bus.bubble) ? ERR_W'(1) : '0;
        end else if (bus.out_valid && bus.bubble && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end
endmodule

// File: tb/tb_tdc_therm_decoder.sv
// tb/tb_tdc_therm_decoder.sv - self-checking bench for tdc_therm_decoder
module tb_tdc_therm_decoder;
    localparam int TAP_W = 90;
    localparam int LAT   = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        err_clr;
    logic [3:0]  err_a;
    logic [15:0] err_b;
    logic [15:0] err_c;

    always #5 clk = ~clk;

    tdc_therm_decoder_if #(.TAP_W(TAP_W)) bus_a ();
    tdc_therm_decoder_if #(.TAP_W(TAP_W)) bus_b ();
    tdc_therm_decoder_if #(.TAP_W(TAP_W)) bus_c ();

    tdc_therm_decoder #(.TAP_W(TAP_W), .GROUP(6), .MODE(0), .ERR_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .err_clr(err_clr), .err_cnt(err_a), .bus(bus_a));
    tdc_therm_decoder #(.TAP_W(TAP_W), .GROUP(6), .MODE(1), .ERR_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .err_clr(err_clr), .err_cnt(err_b), .bus(bus_b));
    tdc_therm_decoder #(.TAP_W(TAP_W), .GROUP(7), .MODE(0), .ERR_W(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .err_clr(err_clr), .err_cnt(err_c), .bus(bus_c));

    typedef struct {
        int due;
        int pc;
        int hi;
        bit bub;
        bit ful;
        bit emp;
    } exp_t;

    exp_t sb[$];
    exp_t hold;
    int   cyc;
    int   checks;
    int   errors;
    int   ecnt_a;
    int   ecnt_bc;
    bit   prev_ob;

    function automatic logic [TAP_W-1:0] therm(input int k);
        logic [TAP_W-1:0] one;
        one = 1;
        return (one << k) - 1;
    endfunction

    function automatic exp_t model(input logic [TAP_W-1:0] q);
        exp_t e;
        e.due = 0;
        e.pc  = $countones(q);
        e.hi  = 0;
        for (int i = 0; i < TAP_W; i++) if (q[i]) e.hi = i + 1;
        e.bub = (q != therm(e.hi));
        e.ful = (q == therm(TAP_W));
        e.emp = (q == '0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input bit ev);
        chk("a_valid", 32'(bus_a.out_valid), 32'(ev));
        chk("b_valid", 32'(bus_b.out_valid), 32'(ev));
        chk("c_valid", 32'(bus_c.out_valid), 32'(ev));
        chk("a_code", 32'(bus_a.code), hold.pc);
        chk("b_code", 32'(bus_b.code), hold.hi);
        chk("c_code", 32'(bus_c.code), hold.pc);
        chk("a_bubble", 32'(bus_a.bubble), 32'(hold.bub));
        chk("b_bubble", 32'(bus_b.bubble), 32'(hold.bub));
        chk("c_bubble", 32'(bus_c.bubble), 32'(hold.bub));
        chk("a_full", 32'(bus_a.full), 32'(hold.ful));
        chk("c_full", 32'(bus_c.full), 32'(hold.ful));
        chk("a_empty", 32'(bus_a.empty), 32'(hold.emp));
        chk("c_empty", 32'(bus_c.empty), 32'(hold.emp));
        chk("a_err", 32'(err_a), ecnt_a);
        chk("b_err", 32'(err_b), ecnt_bc);
        chk("c_err", 32'(err_c), ecnt_bc);
    endtask

    task automatic drive(input bit v, input logic [TAP_W-1:0] q, input bit clr);
        bus_a.in_valid = v; bus_a.Q = q;
        bus_b.in_valid = v; bus_b.Q = q;
        bus_c.in_valid = v; bus_c.Q = q;
        err_clr = clr;
    endtask

    task automatic step(input bit v, input logic [TAP_W-1:0] q, input bit clr);
        exp_t e;
        bit   ev;
        drive(v, q, clr);
        @(posedge clk);
        #1;
        cyc++;
        if (clr) begin
            ecnt_a  = int'(prev_ob);
            ecnt_bc = int'(prev_ob);
        end else if (prev_ob) begin
            if (ecnt_a < 15) ecnt_a++;
            if (ecnt_bc < 65535) ecnt_bc++;
        end
        if (v) begin
            e = model(q);
            e.due = cyc + LAT - 1;
            sb.push_back(e);
        end
        ev = (sb.size() > 0) && (sb[0].due == cyc);
        if (ev) hold = sb.pop_front();
        check_outputs(ev);
        prev_ob = ev && hold.bub;
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        sb.delete();
        hold    = '{default: 0};
        ecnt_a  = 0;
        ecnt_bc = 0;
        prev_ob = 1'b0;
        check_outputs(1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [TAP_W-1:0] rand_word();
        logic [95:0]      w;
        logic [TAP_W-1:0] q;
        int               k;
        w = {$urandom, $urandom, $urandom};
        k = int'($urandom_range(0, TAP_W));
        case ($urandom_range(0, 3))
            0: q = w[TAP_W-1:0];
            1: q = therm(k);
            2: begin q = therm(k); q[$urandom_range(0, TAP_W-1)] ^= 1'b1; end
            default: q = ~therm(k);
        endcase
        return q;
    endfunction

    logic [TAP_W-1:0] qb;

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        err_clr = 1'b0;
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        do_reset();

        // empty word
        step(1'b1, '0, 1'b0);
        flush(6);
        chk("t1_code", 32'(bus_a.code), 0);
        chk("t1_empty", 32'(bus_a.empty), 1);

        // all ones, top tap counted
        step(1'b1, therm(90), 1'b0);
        flush(6);
        chk("t2_code_m0", 32'(bus_a.code), 90);
        chk("t2_code_m1", 32'(bus_b.code), 90);
        chk("t2_full", 32'(bus_a.full), 1);

        // clean 37
        step(1'b1, therm(37), 1'b0);
        flush(6);
        chk("t3_code_m0", 32'(bus_a.code), 37);
        chk("t3_code_m1", 32'(bus_b.code), 37);
        chk("t3_bubble", 32'(bus_a.bubble), 0);
        chk("t3_err", 32'(err_b), 0);

        // two bubbles, one on a group boundary
        qb = therm(40);
        qb[20] = 1'b0;
        qb[12] = 1'b0;
        step(1'b1, qb, 1'b0);
        step(1'b1, qb, 1'b0);
        flush(7);
        chk("t4_code_m0", 32'(bus_a.code), 38);
        chk("t4_code_m1", 32'(bus_b.code), 40);
        chk("t4_code_g7", 32'(bus_c.code), 38);
        chk("t4_bubble", 32'(bus_a.bubble), 1);
        chk("t4_err", 32'(err_b), 2);

        // back-to-back sweep of every clean code
        for (int k = 0; k <= TAP_W; k++) step(1'b1, therm(k), 1'b0);
        flush(7);

        // toggling valid with clean codes
        for (int i = 0; i < 120; i++) step(1'($urandom_range(0, 1)), therm(int'($urandom_range(0, TAP_W))), 1'b0);
        flush(7);

        // mixed random words
        for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)), rand_word(), 1'b0);
        flush(7);

        // saturation of the narrow counter
        for (int i = 0; i < 20; i++) step(1'b1, qb, 1'b0);
        flush(7);
        chk("t6_sat", 32'(err_a), 15);

        // clear coincident with a bubble output
        step(1'b1, qb, 1'b0);
        flush(5);
        step(1'b0, '0, 1'b1);
        chk("t6_clr_a", 32'(err_a), 1);
        chk("t6_clr_b", 32'(err_b), 1);
        step(1'b0, '0, 1'b1);
        chk("t6_clr_idle", 32'(err_a), 0);

        // reset in the middle of a burst
        for (int i = 0; i < 4; i++) step(1'b1, rand_word(), 1'b0);
        do_reset();
        flush(10);
        step(1'b1, therm(5), 1'b0);
        flush(6);
        chk("t6_post_rst", 32'(bus_a.code), 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
